// File: rtl/csr_pkg.sv
// Shared Zicsr encodings, machine-mode CSR address map and sequencer states
// for csr_rmw_unit and csr_addr_check.
package csr_pkg;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam int CSR_NUM = 16;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MISA       = 12'h301;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MIP        = 12'h344;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MARCHID    = 12'hF12;
    localparam logic [11:0] CSR_MIMPID     = 12'hF13;
    localparam logic [11:0] CSR_MHARTID    = 12'hF14;

    localparam logic [CSR_NUM-1:0][11:0] CSR_LEGAL = {
        CSR_MHARTID,   CSR_MIMPID,    CSR_MARCHID,  CSR_MVENDORID,
        CSR_MINSTRETH, CSR_MCYCLEH,   CSR_MINSTRET, CSR_MCYCLE,
        CSR_MIP,       CSR_MCAUSE,    CSR_MEPC,     CSR_MCOUNTEREN,
        CSR_MTVEC,     CSR_MIE,       CSR_MISA,     CSR_MSTATUS
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_WRITE,
        ST_DONE
    } csr_state_e;

    // kind is funct3[1:0]: 01 write, 10 set, 11 clear
    function automatic logic [31:0] rmw_value(input logic [1:0]  kind,
                                              input logic [31:0] old,
                                              input logic [31:0] op);
        logic [31:0] result;
        case (kind)
            2'b10:   result = old | op;
            2'b11:   result = old & ~op;
            default: result = op;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_addr_check.sv
// Legality and read/write-need decode for one Zicsr request. With
// CSR_RMW_ROCHECK_EN defined, writes to the 0xC00-0xFFF range are trapped.
module csr_addr_check
    import csr_pkg::*;
(
    input  logic [11:0] addr,
    input  logic [1:0]  kind,
    input  logic [4:0]  zimm,
    input  logic        rd_nz,
    output logic        read_needed,
    output logic        write_needed,
    output logic        illegal
);

    logic [CSR_NUM-1:0] hit;
    logic               is_write_op;
    logic               bad_op;
    logic               ro_violation;

    genvar gi;
    generate
        for (gi = 0; gi < CSR_NUM; gi++) begin : g_hit
            assign hit[gi] = (addr == CSR_LEGAL[gi]);
        end
    endgenerate

    assign is_write_op  = (kind == 2'b01);
    assign bad_op       = (kind == 2'b00);
    // set/clear with a zero source (x0 or zimm=0) never modifies the CSR
    assign write_needed = is_write_op | (zimm != 5'd0);
    assign read_needed  = ~is_write_op | rd_nz;

`ifdef CSR_RMW_ROCHECK_EN
    assign ro_violation = (addr[11:10] == 2'b11) & write_needed;
`else
    assign ro_violation = 1'b0;
`endif

    assign illegal = bad_op | ~(|hit) | ro_violation;

endmodule

// File: rtl/csr_rmw_unit.sv
// Zicsr read-modify-write sequencer between execute and the CSR file.
// Optional read-only trap on 0xF11-0xF14 writes: define CSR_RMW_ROCHECK_EN.
module csr_rmw_unit
    import csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [2:0]  funct3_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  zimm_i,
    input  logic        rd_nz_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        illegal_o,
    output logic [31:0] rd_data_o,
    output logic [31:0] csr_addr_o,
    output logic        csr_re_o,
    output logic        csr_we_o,
    output logic [31:0] csr_wdata_o,
    input  logic [31:0] csr_rdata_i
);

    csr_state_e  state_reg, state_next;
    logic [11:0] addr_reg;
    logic [1:0]  kind_reg;
    logic [31:0] op_reg;
    logic [31:0] old_reg;
    logic        write_reg;
    logic        illegal_reg;

    logic        read_needed;
    logic        write_needed;
    logic        illegal;
    logic        accept;
    logic [31:0] operand;

    csr_addr_check u_addr_check (
        .addr         (csr_addr_i),
        .kind         (funct3_i[1:0]),
        .zimm         (zimm_i),
        .rd_nz        (rd_nz_i),
        .read_needed  (read_needed),
        .write_needed (write_needed),
        .illegal      (illegal)
    );

    assign accept  = valid_i && (state_reg == ST_IDLE);
    assign operand = funct3_i[2] ? {27'd0, zimm_i} : rs1_data_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (valid_i) begin
                    if (illegal)
                        state_next = ST_DONE;
                    else if (!read_needed)
                        state_next = ST_WRITE;
                    else
                        state_next = ST_READ;
                end
            end
            ST_READ:  state_next = kill_i ? ST_IDLE : ST_CAPT;
            ST_CAPT: begin
                if (kill_i)
                    state_next = ST_IDLE;
                else
                    state_next = write_reg ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // old_reg is cleared on accept so suppressed reads and traps return 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_reg    <= '0;
            kind_reg    <= '0;
            op_reg      <= '0;
            old_reg     <= '0;
            write_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (accept) begin
            addr_reg    <= csr_addr_i;
            kind_reg    <= funct3_i[1:0];
            op_reg      <= operand;
            old_reg     <= '0;
            write_reg   <= write_needed;
            illegal_reg <= illegal;
        end else if (state_reg == ST_CAPT) begin
            old_reg     <= csr_rdata_i;
        end
    end

    assign ready_o     = (state_reg == ST_IDLE);
    assign done_o      = (state_reg == ST_DONE);
    assign illegal_o   = (state_reg == ST_DONE) && illegal_reg;
    assign rd_data_o   = (state_reg == ST_DONE) ? old_reg : 32'd0;
    assign csr_addr_o  = {20'd0, addr_reg};
    assign csr_re_o    = (state_reg == ST_READ);
    assign csr_we_o    = (state_reg == ST_WRITE);
    assign csr_wdata_o = (state_reg == ST_WRITE) ? rmw_value(kind_reg, old_reg, op_reg) : 32'd0;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Self-checking bench for csr_rmw_unit: directed table, multi-cycle kill/reset
// sequences and randomized requests against a spec-level reference model.
module tb_csr_rmw_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [11:0] csr_addr_i;
    logic [31:0] rs1_data_i;
    logic [4:0]  zimm_i;
    logic        rd_nz_i;
    logic        kill_i;
    logic        ready_o;
    logic        done_o;
    logic        illegal_o;
    logic [31:0] rd_data_o;
    logic [31:0] csr_addr_o;
    logic        csr_re_o;
    logic        csr_we_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_rdata_i;

    int tests = 0;
    int fails = 0;

    csr_rmw_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .funct3_i    (funct3_i),
        .csr_addr_i  (csr_addr_i),
        .rs1_data_i  (rs1_data_i),
        .zimm_i      (zimm_i),
        .rd_nz_i     (rd_nz_i),
        .kill_i      (kill_i),
        .ready_o     (ready_o),
        .done_o      (done_o),
        .illegal_o   (illegal_o),
        .rd_data_o   (rd_data_o),
        .csr_addr_o  (csr_addr_o),
        .csr_re_o    (csr_re_o),
        .csr_we_o    (csr_we_o),
        .csr_wdata_o (csr_wdata_o),
        .csr_rdata_i (csr_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // CSR register file with registered read data; pre_* is a bench-only preload port
    logic [31:0] csr_mem [4096];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = 12'd0;
    logic [31:0] pre_data = 32'd0;
    always @(posedge clk_i) begin
        if (pre_we)
            csr_mem[pre_addr] <= pre_data;
        else if (csr_we_o)
            csr_mem[csr_addr_o[11:0]] <= csr_wdata_o;
        if (csr_re_o)
            csr_rdata_i <= csr_mem[csr_addr_o[11:0]];
    end

    // Reference model state: expected contents of the CSR file
    logic [31:0] ref_mem [4096];
    logic [11:0] legal_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h306, 12'h341,
                                    12'h342, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                    12'hF11, 12'hF12, 12'hF13, 12'hF14};

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic        rd_nz;
        logic        ill;
        int          lat;
        logic [31:0] rd;
        logic        re;
        logic        we;
        logic [31:0] wd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk_i);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk_i);
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Spec-level expectation for a single request
    function automatic void model(input logic [2:0] f3, input logic [11:0] a,
                                  input logic [31:0] rs1, input logic [4:0] z, input logic rdnz,
                                  output logic ill, output int lat, output logic [31:0] rd,
                                  output logic re, output logic we, output logic [31:0] wd);
        logic        known = 1'b0;
        logic [31:0] op, old;
        logic        rd_en, wr_en;
        foreach (legal_tab[i]) if (a == legal_tab[i]) known = 1'b1;
        op    = f3[2] ? {27'd0, z} : rs1;
        wr_en = (f3[1:0] == 2'b01) || (z != 5'd0);
        rd_en = !((f3[1:0] == 2'b01) && !rdnz);
        ill   = !known || (f3[1:0] == 2'b00);
`ifdef CSR_RMW_ROCHECK_EN
        if (a[11:10] == 2'b11 && wr_en) ill = 1'b1;
`endif
        if (ill) begin
            lat = 1; rd = 32'd0; re = 1'b0; we = 1'b0; wd = 32'd0;
        end else begin
            old = rd_en ? ref_mem[a] : 32'd0;
            case (f3[1:0])
                2'b01:   wd = op;
                2'b10:   wd = old | op;
                default: wd = old & ~op;
            endcase
            lat = 1 + (rd_en ? 2 : 0) + (wr_en ? 1 : 0);
            rd  = old;
            re  = rd_en;
            we  = wr_en;
        end
    endfunction

    // Drive one request and observe it through done_o plus one cycle
    task automatic run_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                           input logic [4:0] z, input logic rdnz,
                           output int lat, output logic ill, output logic [31:0] rd,
                           output int re_cnt, output int we_cnt, output logic [31:0] wd,
                           output logic proto_ok, output logic rdy_after);
        for (int w = 0; w < 10 && !ready_o; w++) @(negedge clk_i);
        valid_i = 1'b1; funct3_i = f3; csr_addr_i = a; rs1_data_i = rs1; zimm_i = z; rd_nz_i = rdnz;
        @(posedge clk_i);
        lat = 0; ill = 1'b0; rd = 32'd0; re_cnt = 0; we_cnt = 0; wd = 32'd0; proto_ok = 1'b1;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk_i);
            if (csr_re_o) begin
                re_cnt++;
                if (csr_addr_o != {20'd0, a}) proto_ok = 1'b0;
            end
            if (csr_we_o) begin
                we_cnt++;
                wd = csr_wdata_o;
                if (csr_addr_o != {20'd0, a}) proto_ok = 1'b0;
            end
            if ((csr_re_o && csr_we_o) || ready_o) proto_ok = 1'b0;
            if (done_o) begin
                lat = k; ill = illegal_o; rd = rd_data_o;
            end
            if (k == 1) begin
                valid_i = 1'b0; funct3_i = 3'($urandom); csr_addr_i = 12'($urandom);
                rs1_data_i = $urandom; zimm_i = 5'($urandom); rd_nz_i = 1'($urandom);
            end
        end
        @(negedge clk_i);
        rdy_after = ready_o;
    endtask

    task automatic do_txn(input string tag, input vec_t v);
        int          lat, re_cnt, we_cnt;
        logic        ill, proto_ok, rdy_after;
        logic [31:0] rd, wd;
        run_req(v.f3, v.addr, v.rs1, v.zimm, v.rd_nz, lat, ill, rd, re_cnt, we_cnt, wd, proto_ok, rdy_after);
        $display("[TB] %s f3=%b addr=%03h rs1=%08h zimm=%0d rd_nz=%0d -> lat=%0d ill=%0d rd=%08h re=%0d we=%0d wd=%08h",
                 tag, v.f3, v.addr, v.rs1, v.zimm, v.rd_nz, lat, ill, rd, re_cnt, we_cnt, wd);
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " illegal"}, {31'd0, ill}, {31'd0, v.ill});
        chk({tag, " rd_data"}, rd, v.rd);
        chk({tag, " read_count"}, 32'(re_cnt), {31'd0, v.re});
        chk({tag, " write_count"}, 32'(we_cnt), {31'd0, v.we});
        if (v.we) chk({tag, " wdata"}, wd, v.wd);
        chk({tag, " protocol"}, {31'd0, proto_ok}, 32'd1);
        chk({tag, " ready_after_done"}, {31'd0, rdy_after}, 32'd1);
        if (v.we) ref_mem[v.addr] = v.wd;
    endtask

    // Kill while in READ (kc=1) or CAPT (kc=2): no write, no done, back to idle
    task automatic kill_test(input int kc);
        logic saw_we = 1'b0, saw_done = 1'b0;
        valid_i = 1'b1; funct3_i = 3'b010; csr_addr_i = 12'h304;
        rs1_data_i = 32'h0000_00F0; zimm_i = 5'd3; rd_nz_i = 1'b1;
        @(posedge clk_i);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            if (csr_we_o) saw_we = 1'b1;
            if (done_o) saw_done = 1'b1;
            if (k == kc + 1) begin
                kill_i = 1'b0;
                chk($sformatf("kill%0d ready_next", kc), {31'd0, ready_o}, 32'd1);
            end
            if (k == kc) kill_i = 1'b1;
        end
        $display("[TB] kill at cycle %0d: we_seen=%0d done_seen=%0d", kc, saw_we, saw_done);
        chk($sformatf("kill%0d no_write", kc), {31'd0, saw_we}, 32'd0);
        chk($sformatf("kill%0d no_done", kc), {31'd0, saw_done}, 32'd0);
        chk($sformatf("kill%0d csr_unchanged", kc), csr_mem[12'h304], ref_mem[12'h304]);
    endtask

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [4:0]  z;

        rst_i = 1'b1; valid_i = 1'b0; funct3_i = '0; csr_addr_i = '0;
        rs1_data_i = '0; zimm_i = '0; rd_nz_i = 1'b0; kill_i = 1'b0;

        foreach (legal_tab[i]) preload(legal_tab[i], $urandom);
        preload(12'h300, 32'h0000_1800);
        preload(12'h305, 32'h0000_0000);
        preload(12'h304, 32'h0000_0880);
        preload(12'hF11, 32'h0000_0011);
        preload(12'hF12, 32'h0000_0012);
        preload(12'hF14, 32'h0000_0005);

        chk("reset ready_o", {31'd0, ready_o}, 32'd1);
        chk("reset done_o", {31'd0, done_o}, 32'd0);
        chk("reset illegal_o", {31'd0, illegal_o}, 32'd0);
        chk("reset csr_re_o", {31'd0, csr_re_o}, 32'd0);
        chk("reset csr_we_o", {31'd0, csr_we_o}, 32'd0);
        chk("reset csr_wdata_o", csr_wdata_o, 32'd0);
        chk("reset rd_data_o", rd_data_o, 32'd0);
        chk("reset csr_addr_o", csr_addr_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // f3, addr, rs1, zimm, rd_nz, ill, lat, rd, re, we, wd
        vecs.push_back('{3'b001, 12'h305, 32'h8000_0100, 5'd1,  1'b1, 1'b0, 4, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0100});
        vecs.push_back('{3'b010, 12'h300, 32'h0000_0008, 5'd5,  1'b1, 1'b0, 4, 32'h0000_1800, 1'b1, 1'b1, 32'h0000_1808});
        vecs.push_back('{3'b111, 12'h300, 32'hFFFF_FFFF, 5'd8,  1'b1, 1'b0, 4, 32'h0000_1808, 1'b1, 1'b1, 32'h0000_1800});
        vecs.push_back('{3'b010, 12'hF14, 32'h0000_1234, 5'd0,  1'b1, 1'b0, 3, 32'h0000_0005, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{3'b001, 12'h341, 32'h0000_1234, 5'd3,  1'b0, 1'b0, 2, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_1234});
        vecs.push_back('{3'b001, 12'h7C0, 32'h0000_0055, 5'd1,  1'b1, 1'b1, 1, 32'h0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{3'b100, 12'h300, 32'h0000_0055, 5'd1,  1'b1, 1'b1, 1, 32'h0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{3'b000, 12'h341, 32'h0000_0055, 5'd1,  1'b1, 1'b1, 1, 32'h0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{3'b110, 12'h304, 32'h0000_0000, 5'd31, 1'b0, 1'b0, 4, 32'h0000_0880, 1'b1, 1'b1, 32'h0000_089F});
        vecs.push_back('{3'b111, 12'hF12, 32'h0000_0000, 5'd0,  1'b1, 1'b0, 3, 32'h0000_0012, 1'b1, 1'b0, 32'h0});
`ifdef CSR_RMW_ROCHECK_EN
        vecs.push_back('{3'b001, 12'hF11, 32'hDEAD_BEEF, 5'd1,  1'b1, 1'b1, 1, 32'h0, 1'b0, 1'b0, 32'h0});
`else
        vecs.push_back('{3'b001, 12'hF11, 32'hDEAD_BEEF, 5'd1,  1'b1, 1'b0, 4, 32'h0000_0011, 1'b1, 1'b1, 32'hDEAD_BEEF});
`endif
        foreach (vecs[i]) do_txn($sformatf("vec%0d", i), vecs[i]);
        chk("F11 contents", csr_mem[12'hF11], ref_mem[12'hF11]);

        kill_test(1);
        kill_test(2);

        // Reset asserted while the unit is in WRITE
        valid_i = 1'b1; funct3_i = 3'b001; csr_addr_i = 12'h342;
        rs1_data_i = 32'h0000_ABCD; zimm_i = 5'd1; rd_nz_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        chk("rstwr we_before", {31'd0, csr_we_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rstwr we_after", {31'd0, csr_we_o}, 32'd0);
        chk("rstwr ready", {31'd0, ready_o}, 32'd1);
        chk("rstwr addr_cleared", csr_addr_o, 32'd0);
        chk("rstwr wdata", csr_wdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rstwr csr_unchanged", csr_mem[12'h342], ref_mem[12'h342]);
        $display("[TB] reset during write: csr[342]=%08h", csr_mem[12'h342]);
        @(negedge clk_i);

        // Randomized requests against the reference model
        for (int n = 0; n < 150; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : legal_tab[$urandom_range(0, 15)];
            z  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            v.f3 = f3; v.addr = a; v.rs1 = $urandom; v.zimm = z; v.rd_nz = 1'($urandom);
            model(v.f3, v.addr, v.rs1, v.zimm, v.rd_nz, v.ill, v.lat, v.rd, v.re, v.we, v.wd);
            do_txn($sformatf("rnd%0d", n), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
